comb_stim_sequencer: RTL and testbench

Sequential stimulus controller for the gate-level combinational netlists under test, including netlists that contain combinational feedback loops. It walks the primary inputs through a programmed vector range and holds each vector for a fixed settle window. It then samples the netlist outputs twice on consecutive cycles and streams one result per vector over a valid/ready port. A vector whose two samples differ is flagged unstable; these vectors mark where a feedback loop is oscillating and where loop-breaker analysis should focus.

---
 rtl/comb_seq_pkg.sv | 22 ++
 rtl/comb_seq_timer.sv | 37 +++
 rtl/comb_stim_sequencer.sv | 154 +++++++++++++++
 tb/tb_comb_stim_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comb_seq_pkg.sv
// Shared types and default widths for the combinational-netlist stimulus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package comb_seq_pkg;

  localparam int DEF_IN_W  = 13;
  localparam int DEF_OUT_W = 5;
  localparam int DEF_CNT_W = 16;

  // Settle window counter width; SETTLE is limited to 1..255.
  localparam int TMR_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMP_A = 3'd2,
    S_SAMP_B = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/comb_seq_timer.sv
// Loadable down-counter timing the per-vector settle window.
// Latency: load takes effect on the next edge; zero flag is decoded from the count register.
// Backpressure: none; decrements whenever i_dec is high and the count is non-zero.
//
// Ports: clk/rst_n       clock, async active-low reset
//        i_load          load i_load_val (wins over i_dec)
//        i_load_val      value to load
//        i_dec           decrement enable
//        o_zero          count register equals zero
module comb_seq_timer
  import comb_seq_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/comb_stim_sequencer.sv
// Sweeps netlist inputs over [vec_first, vec_last], settles, double-samples resp, streams one result per vector.
// Latency: res_valid rises SETTLE+2 cycles after start is taken; SETTLE+3 cycles per vector with res_ready high.
// Backpressure: EMIT holds result and stim while res_ready is low; abort drops any pending result.
//
// Ports: clk/rst_n                   clock, async active-low reset
//        start/abort                 sweep control (start in IDLE only, abort in any other state)
//        vec_first/vec_last          inclusive sweep range, latched at start
//        stim                        registered drive to netlist inputs
//        resp                        netlist outputs (sampled twice per vector)
//        res_valid/res_ready         result handshake
//        res_vec/res_out/res_unstable result payload
//        busy/done/unstable_cnt      status
module comb_stim_sequencer
  import comb_seq_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SETTLE = 4,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  vec_first,
  input  logic [IN_W-1:0]  vec_last,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IN_W-1:0]  res_vec,
  output logic [OUT_W-1:0] res_out,
  output logic             res_unstable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] unstable_cnt
);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);

  seq_state_e       r_state;
  logic [IN_W-1:0]  r_stim;
  logic [IN_W-1:0]  r_last;
  logic [OUT_W-1:0] r_samp_a;
  logic [IN_W-1:0]  r_res_vec;
  logic [OUT_W-1:0] r_res_out;
  logic             r_res_unst;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_unst_cnt;

  logic w_start_ok;
  logic w_hs;
  logic w_at_last;
  logic w_tmr_load;
  logic w_tmr_dec;
  logic w_tmr_zero;

  assign w_start_ok = (r_state == S_IDLE) && start && (vec_first <= vec_last);
  // A handshake only counts when abort is not pulling the FSM back to IDLE.
  assign w_hs       = (r_state == S_EMIT) && res_ready && !abort;
  // Comparing against the latched last before incrementing is what prevents wrap at all-ones.
  assign w_at_last  = (r_stim == r_last);
  assign w_tmr_load = w_start_ok || (w_hs && !w_at_last);
  assign w_tmr_dec  = (r_state == S_SETTLE);

  comb_seq_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (SETTLE_LD),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_stim     <= '0;
      r_last     <= '0;
      r_samp_a   <= '0;
      r_res_vec  <= '0;
      r_res_out  <= '0;
      r_res_unst <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_unst_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_last     <= vec_last;
              r_stim     <= vec_first;
              r_unst_cnt <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_SETTLE;
            end
          end
          // Timer was loaded with SETTLE-1, so checking zero here gives SETTLE cycles in this state.
          S_SETTLE: begin
            if (w_tmr_zero) r_state <= S_SAMP_A;
          end
          // resp comes from a possibly oscillating netlist; the two back-to-back samples
          // are compared only to expose instability, not to resolve it.
          S_SAMP_A: begin
            r_samp_a <= resp;
            r_state  <= S_SAMP_B;
          end
          S_SAMP_B: begin
            r_res_vec  <= r_stim;
            r_res_out  <= resp;
            r_res_unst <= (r_samp_a != resp);
            r_state    <= S_EMIT;
          end
          S_EMIT: begin
            if (w_hs) begin
              if (r_res_unst && (r_unst_cnt != '1)) r_unst_cnt <= r_unst_cnt + 1'b1;
              if (w_at_last) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_stim  <= r_stim + 1'b1;
                r_state <= S_SETTLE;
              end
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign stim         = r_stim;
  assign res_valid    = (r_state == S_EMIT);
  assign res_vec      = r_res_vec;
  assign res_out      = r_res_out;
  assign res_unstable = r_res_unst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign unstable_cnt = r_unst_cnt;

endmodule

// File: tb/tb_comb_stim_sequencer.sv
// Directed bench for comb_stim_sequencer: table of sweeps plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: exercised explicitly via res_ready.
module tb_comb_stim_sequencer;

  localparam int IN_W   = 13;
  localparam int OUT_W  = 5;
  localparam int SETTLE = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [IN_W-1:0]  vec_first = '0;
  logic [IN_W-1:0]  vec_last = '0;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] resp;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [IN_W-1:0]  res_vec;
  logic [OUT_W-1:0] res_out;
  logic             res_unstable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] unstable_cnt;

  int total = 0;
  int bad   = 0;

  // Netlist model: resp follows stim; selected vectors oscillate on bit 0.
  logic tgl = 1'b0;
  logic tog_en = 1'b0;
  logic tog_all = 1'b0;

  always #5 clk = ~clk;
  always @(negedge clk) tgl = ~tgl;

  always_comb begin
    resp = stim[OUT_W-1:0];
    if (tog_en && (tog_all || (stim == 13'd2))) resp[0] = stim[0] ^ tgl;
  end

  comb_stim_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .vec_first    (vec_first),
    .vec_last     (vec_last),
    .stim         (stim),
    .resp         (resp),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_vec      (res_vec),
    .res_out      (res_out),
    .res_unstable (res_unstable),
    .busy         (busy),
    .done         (done),
    .unstable_cnt (unstable_cnt)
  );

  typedef struct {
    logic [IN_W-1:0] first;
    logic [IN_W-1:0] last;
    bit              tog;
    int              exp_n;
    int              exp_unst;
  } sweep_t;

  sweep_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && (i < limit)) begin
      if (res_valid) ok = 1'b1;
      else begin
        @(negedge clk);
        i++;
      end
    end
  endtask

  task automatic start_sweep(input logic [IN_W-1:0] f, input logic [IN_W-1:0] l);
    vec_first = f;
    vec_last  = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_sweep(input sweep_t v);
    int c, k, last_c;
    logic [IN_W-1:0] ev;
    logic eu;
    tog_en    = v.tog;
    tog_all   = 1'b0;
    res_ready = 1'b1;
    start_sweep(v.first, v.last);
    chk("start_stim", 32'(stim), 32'(v.first));
    chk("start_busy", 32'(busy), 32'd1);
    c = 0; k = 0; last_c = 0;
    while ((k < v.exp_n) && (c < 500)) begin
      if (res_valid) begin
        ev = v.first + IN_W'(k);
        eu = v.tog && (ev == 13'd2);
        chk("res_vec", 32'(res_vec), 32'(ev));
        chk("res_unstable", 32'(res_unstable), 32'(eu));
        if (!eu) chk("res_out", 32'(res_out), 32'(ev[OUT_W-1:0]));
        if (k == 0) chk("first_latency", c, SETTLE + 2);
        else        chk("vector_period", c - last_c, SETTLE + 3);
        last_c = c;
        k++;
      end
      @(negedge clk);
      c++;
    end
    chk("n_results", k, v.exp_n);
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_in_done", 32'(res_valid), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("unstable_cnt", 32'(unstable_cnt), 32'(v.exp_unst));
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("stim_hold", 32'(stim), 32'(v.last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int seen;

    tbl[0] = '{first: 13'd0,      last: 13'd3,      tog: 1'b0, exp_n: 4, exp_unst: 0};
    tbl[1] = '{first: 13'd10,     last: 13'd12,     tog: 1'b1, exp_n: 3, exp_unst: 0};
    tbl[2] = '{first: 13'h1FFF,   last: 13'h1FFF,   tog: 1'b0, exp_n: 1, exp_unst: 0};
    tbl[3] = '{first: 13'h1FFE,   last: 13'h1FFF,   tog: 1'b0, exp_n: 2, exp_unst: 0};
    tbl[4] = '{first: 13'd0,      last: 13'd3,      tog: 1'b1, exp_n: 4, exp_unst: 1};

    // Reset state
    #1;
    chk("rst_stim", 32'(stim), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(unstable_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

    // Reversed range is ignored and leaves the previous count intact.
    start_sweep(13'd5, 13'd3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || res_valid) seen++;
      @(negedge clk);
    end
    chk("rev_activity", seen, 0);
    chk("rev_cnt_kept", 32'(unstable_cnt), 32'd1);

    // Backpressure on vector 1.
    tog_en = 1'b0;
    res_ready = 1'b1;
    start_sweep(13'd0, 13'd3);
    wait_valid(50, ok); chk("bp_wait0", 32'(ok), 32'd1);
    chk("bp_vec0", 32'(res_vec), 32'd0);
    @(negedge clk);
    res_ready = 1'b0;
    wait_valid(50, ok); chk("bp_wait1", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_vec", 32'(res_vec), 32'd1);
      chk("bp_hold_out", 32'(res_out), 32'd1);
      chk("bp_hold_stim", 32'(stim), 32'd1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    chk("bp_release_vec", 32'(res_vec), 32'd1);
    @(negedge clk);
    chk("bp_no_dup", 32'(res_valid), 32'd0);
    wait_valid(50, ok); chk("bp_wait2", 32'(ok), 32'd1);
    chk("bp_vec2", 32'(res_vec), 32'd2);
    @(negedge clk);
    wait_valid(50, ok); chk("bp_wait3", 32'(ok), 32'd1);
    chk("bp_vec3", 32'(res_vec), 32'd3);
    @(negedge clk);
    chk("bp_done", 32'(done), 32'd1);
    @(negedge clk);

    // Abort in SAMP_A of vector 2.
    start_sweep(13'd0, 13'd3);
    wait_valid(50, ok); chk("ab_wait0", 32'(ok), 32'd1);
    @(negedge clk);
    wait_valid(50, ok); chk("ab_wait1", 32'(ok), 32'd1);
    @(negedge clk);
    repeat (SETTLE) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_valid", 32'(res_valid), 32'd0);
    chk("ab_stim", 32'(stim), 32'd2);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || res_valid || busy) seen++;
      @(negedge clk);
    end
    chk("ab_quiet", seen, 0);
    chk("ab_stim_hold", 32'(stim), 32'd2);

    // Asynchronous reset while a result waits in EMIT.
    tog_en  = 1'b1;
    tog_all = 1'b1;
    res_ready = 1'b1;
    start_sweep(13'd5, 13'd7);
    wait_valid(50, ok); chk("rs_wait5", 32'(ok), 32'd1);
    @(negedge clk);
    res_ready = 1'b0;
    wait_valid(50, ok); chk("rs_wait6", 32'(ok), 32'd1);
    chk("rs_pre_cnt", 32'(unstable_cnt), 32'd1);
    chk("rs_pre_unst", 32'(res_unstable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_stim", 32'(stim), 32'd0);
    chk("rs_valid", 32'(res_valid), 32'd0);
    chk("rs_vec", 32'(res_vec), 32'd0);
    chk("rs_out", 32'(res_out), 32'd0);
    chk("rs_unst", 32'(res_unstable), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_cnt", 32'(unstable_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tog_en = 1'b0;
    tog_all = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
